puf_eval_ctrl: RTL and testbench

Sequencing controller for the bistable-ring PUF. It accepts a 32-bit challenge over a valid/ready handshake and drives the PUF through a fixed number of reset/settle/sample evaluations. The per-bit samples are majority-voted into a response plus a mask of unstable bits, returned over a second valid/ready handshake. It sits between the user-project host interface (Wishbone glue or IO pads) and the PUF core, replacing the direct pad-to-PUF wiring.

---
 rtl/puf_eval_ctrl.sv | 152 +++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences the bistable-ring PUF through repeated
// reset/settle/sample evaluations for one challenge, then returns a
// majority-voted response and a mask of bits whose samples disagreed.
module puf_eval_ctrl #(
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int VOTES         = 5
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_challenge,
  output logic        puf_reset,
  output logic [31:0] puf_challenge,
  input  logic [31:0] puf_rsp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_unstable,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRECHARGE = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_SAMPLE    = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam logic [7:0] PRE_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] SET_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] VOTE_N    = 4'(VOTES);
  localparam logic [3:0] VOTE_HALF = 4'(VOTES / 2);

  // A bit resolves to 1 when strictly more than half of its samples were 1.
  function automatic logic vote_major(input logic [3:0] ones);
    return ones > VOTE_HALF;
  endfunction

  // A bit is unstable unless all samples agreed (all zero or all one).
  function automatic logic vote_unstable(input logic [3:0] ones);
    return (ones != 4'd0) && (ones != VOTE_N);
  endfunction

  logic [2:0]        state_q, state_d;
  logic [7:0]        phase_q, phase_d;
  logic [3:0]        vote_q, vote_d;
  logic [31:0][3:0]  ones_q, ones_d;
  logic [31:0]       sync1_q, sync1_d;
  logic [31:0]       sync2_q, sync2_d;
  logic [31:0]       chal_q, chal_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       unst_q, unst_d;

  // Next-state logic: phase timing, vote accumulation and result capture.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vote_d  = vote_q;
    ones_d  = ones_q;
    chal_d  = chal_q;
    data_d  = data_q;
    unst_d  = unst_q;
    sync1_d = puf_rsp;
    sync2_d = sync1_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          chal_d  = req_challenge;
          ones_d  = '0;
          vote_d  = '0;
          phase_d = '0;
          state_d = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        if (phase_q == PRE_LAST) begin
          phase_d = '0;
          state_d = ST_SETTLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (phase_q == SET_LAST) begin
          phase_d = '0;
          state_d = ST_SAMPLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        // Sample the synchronized response; the settle window is at least
        // two cycles so the synchronizer has flushed any pre-reset value.
        for (int i = 0; i < 32; i++) begin
          ones_d[i] = ones_q[i] + {3'b000, sync2_q[i]};
        end
        vote_d = vote_q + 4'd1;
        if (vote_d == VOTE_N) begin
          state_d = ST_DONE;
          for (int i = 0; i < 32; i++) begin
            data_d[i] = vote_major(ones_d[i]);
            unst_d[i] = vote_unstable(ones_d[i]);
          end
        end else begin
          state_d = ST_PRECHARGE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, synchronizer and result registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      chal_q  <= '0;
      data_q  <= '0;
      unst_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      chal_q  <= chal_d;
      data_q  <= data_d;
      unst_q  <= unst_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign puf_reset     = (state_q == ST_IDLE) || (state_q == ST_PRECHARGE) ||
                         (state_q == ST_DONE);
  assign puf_challenge = chal_q;
  assign rsp_data      = data_q;
  assign rsp_unstable  = unst_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: directed bench for puf_eval_ctrl with a default
// instance (4/16/5) and a minimal instance (1/2/1).
`timescale 1ns/1ps
module tb_puf_eval_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid0 = 0, req_valid1 = 0;
  logic [31:0] req_chal0 = '0, req_chal1 = '0;
  logic [31:0] puf_rsp0 = '0, puf_rsp1 = '0;
  logic        rsp_ready0 = 0, rsp_ready1 = 0;
  logic        req_ready0, req_ready1, puf_reset0, puf_reset1;
  logic        rsp_valid0, rsp_valid1, busy0, busy1;
  logic [31:0] puf_chal0, puf_chal1, rsp_data0, rsp_data1, rsp_unst0, rsp_unst1;

  puf_eval_ctrl dut0 (
    .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_challenge(req_chal0),
    .puf_reset(puf_reset0), .puf_challenge(puf_chal0), .puf_rsp(puf_rsp0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
    .rsp_unstable(rsp_unst0), .busy(busy0)
  );

  puf_eval_ctrl #(.RESET_CYCLES(1), .SETTLE_CYCLES(2), .VOTES(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_challenge(req_chal1),
    .puf_reset(puf_reset1), .puf_challenge(puf_chal1), .puf_rsp(puf_rsp1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .rsp_unstable(rsp_unst1), .busy(busy1)
  );

  // Monitor view of whichever instance is under test.
  bit          sel = 0;
  logic        m_req_ready, m_puf_reset, m_rsp_valid, m_busy;
  logic [31:0] m_chal, m_data, m_unst;
  always_comb begin
    m_req_ready = sel ? req_ready1 : req_ready0;
    m_puf_reset = sel ? puf_reset1 : puf_reset0;
    m_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
    m_busy      = sel ? busy1      : busy0;
    m_chal      = sel ? puf_chal1  : puf_chal0;
    m_data      = sel ? rsp_data1  : rsp_data0;
    m_unst      = sel ? rsp_unst1  : rsp_unst0;
  end

  int          n_tot = 0;
  int          n_bad = 0;
  logic [31:0] pat [0:15];
  int          valid_cyc, nv;
  int          pre_len [0:15];
  int          low_len [0:15];
  logic [31:0] chal_at1;

  // Accept a challenge, then walk cycles (cycle c ends at the c-th rising
  // edge after the accept edge), recording puf_reset high/low run lengths
  // and presenting pat[vote] to the PUF input whenever puf_reset falls.
  task automatic run_eval(input bit s, input logic [31:0] chal, input int stop_at);
    int  cur_hi, cur_lo;
    bit  prev;
    valid_cyc = -1; nv = 0; cur_hi = 0; cur_lo = 0; prev = 1'b1;
    sel = s;
    @(negedge clk);
    n_tot++;
    if (m_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL accept_ready: got %b want 1", m_req_ready);
    end
    if (s) begin req_valid1 = 1; req_chal1 = chal; end
    else   begin req_valid0 = 1; req_chal0 = chal; end
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid0 = 0; req_valid1 = 0;
        chal_at1 = m_chal;
      end
      if (m_puf_reset) begin
        if (!prev) begin low_len[nv] = cur_lo; nv++; cur_lo = 0; end
        cur_hi++;
      end else begin
        if (prev) begin
          pre_len[nv] = cur_hi; cur_hi = 0;
          if (s) puf_rsp1 = pat[nv]; else puf_rsp0 = pat[nv];
        end
        cur_lo++;
      end
      prev = m_puf_reset;
      if (m_rsp_valid) begin valid_cyc = c; break; end
      if (stop_at != 0 && c == stop_at) break;
    end
  endtask

  task automatic do_handshake(input bit s);
    @(negedge clk);
    if (s) rsp_ready1 = 1; else rsp_ready0 = 1;
    @(negedge clk);
    rsp_ready0 = 0; rsp_ready1 = 0;
  endtask

  // Wait (bounded) for the current evaluation to finish and retire it.
  task automatic finish_eval(input bit s, output bit ok);
    ok = 1'b0;
    sel = s;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (m_rsp_valid) begin ok = 1'b1; break; end
    end
    if (ok) do_handshake(s);
  endtask

  task automatic test_reset;
    sel = 0;
    wb_rst_ni = 0;
    @(negedge clk); @(negedge clk);
    n_tot++; if (m_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", m_req_ready); end
    n_tot++; if (m_puf_reset !== 1'b1) begin n_bad++; $display("FAIL rst_puf_reset: got %b want 1", m_puf_reset); end
    n_tot++; if (m_chal !== 32'h0) begin n_bad++; $display("FAIL rst_puf_chal: got %h want 0", m_chal); end
    n_tot++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", m_rsp_valid); end
    n_tot++; if (m_data !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_data: got %h want 0", m_data); end
    n_tot++; if (m_unst !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_unst: got %h want 0", m_unst); end
    n_tot++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", m_busy); end
    wb_rst_ni = 1;
    @(negedge clk);
    n_tot++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", m_busy); end
  endtask

  task automatic test_basic;
    for (int v = 0; v < 16; v++) pat[v] = 32'hA5A5_0F0F;
    run_eval(0, 32'h1234_5678, 0);
    n_tot++; if (chal_at1 !== 32'h1234_5678) begin n_bad++; $display("FAIL basic_chal_c1: got %h want 12345678", chal_at1); end
    n_tot++; if (valid_cyc !== 106) begin n_bad++; $display("FAIL basic_valid_cycle: got %0d want 106", valid_cyc); end
    n_tot++; if (m_data !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL basic_data: got %h want a5a50f0f", m_data); end
    n_tot++; if (m_unst !== 32'h0) begin n_bad++; $display("FAIL basic_unst: got %h want 0", m_unst); end
    n_tot++; if (m_puf_reset !== 1'b1) begin n_bad++; $display("FAIL done_puf_reset: got %b want 1", m_puf_reset); end
    n_tot++; if (nv !== 5) begin n_bad++; $display("FAIL phase_votes: got %0d want 5", nv); end
    // The low window of each vote is SETTLE (16) plus the single SAMPLE cycle.
    for (int v = 0; v < 5; v++) begin
      n_tot++; if (pre_len[v] !== 4) begin n_bad++; $display("FAIL phase_pre[%0d]: got %0d want 4", v, pre_len[v]); end
      n_tot++; if (low_len[v] !== 17) begin n_bad++; $display("FAIL phase_settle[%0d]: got %0d want 17", v, low_len[v]); end
    end
    do_handshake(0);
    n_tot++; if (m_req_ready !== 1'b1) begin n_bad++; $display("FAIL post_hs_ready: got %b want 1", m_req_ready); end
    n_tot++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_hs_valid: got %b want 0", m_rsp_valid); end
  endtask

  task automatic test_flaky;
    pat[0] = 32'h8; pat[1] = 32'h0; pat[2] = 32'h8; pat[3] = 32'h8; pat[4] = 32'h0;
    run_eval(0, 32'h0000_00F1, 0);
    n_tot++; if (m_data !== 32'h0000_0008) begin n_bad++; $display("FAIL flaky_data: got %h want 00000008", m_data); end
    n_tot++; if (m_unst !== 32'h0000_0008) begin n_bad++; $display("FAIL flaky_unst: got %h want 00000008", m_unst); end
    do_handshake(0);
    // bit3 -> 3 ones (1, unstable); bit0 -> 2 ones (0, unstable); bits 31:28 always 1.
    pat[0] = 32'hF000_0009; pat[1] = 32'hF000_0001; pat[2] = 32'hF000_0008;
    pat[3] = 32'hF000_0008; pat[4] = 32'hF000_0000;
    run_eval(0, 32'h0000_00F2, 0);
    n_tot++; if (m_data !== 32'hF000_0008) begin n_bad++; $display("FAIL mixed_data: got %h want f0000008", m_data); end
    n_tot++; if (m_unst !== 32'h0000_0009) begin n_bad++; $display("FAIL mixed_unst: got %h want 00000009", m_unst); end
    do_handshake(0);
  endtask

  task automatic test_backpressure;
    bit ok;
    for (int v = 0; v < 16; v++) pat[v] = 32'h0F0F_F0F0;
    run_eval(0, 32'h7777_1111, 0);
    req_valid0 = 1; req_chal0 = 32'hCAFE_F00D;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_tot++; if (m_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid@%0d: got %b want 1", c, m_rsp_valid); end
      n_tot++; if (m_data !== 32'h0F0F_F0F0) begin n_bad++; $display("FAIL bp_data@%0d: got %h want 0f0ff0f0", c, m_data); end
      n_tot++; if (m_req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready@%0d: got %b want 0", c, m_req_ready); end
      n_tot++; if (m_chal !== 32'h7777_1111) begin n_bad++; $display("FAIL bp_chal@%0d: got %h want 77771111", c, m_chal); end
    end
    rsp_ready0 = 1;
    @(negedge clk);
    rsp_ready0 = 0;
    n_tot++; if (m_req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_ready: got %b want 1", m_req_ready); end
    n_tot++; if (m_chal !== 32'h7777_1111) begin n_bad++; $display("FAIL bp_idle_chal: got %h want 77771111", m_chal); end
    @(negedge clk);
    req_valid0 = 0;
    n_tot++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL bp_second_busy: got %b want 1", m_busy); end
    n_tot++; if (m_chal !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL bp_second_chal: got %h want cafef00d", m_chal); end
    finish_eval(0, ok);
    n_tot++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_second_done: got %b want 1", ok); end
  endtask

  task automatic test_reset_mid;
    for (int v = 0; v < 16; v++) pat[v] = 32'h3C3C_C3C3;
    run_eval(0, 32'h5555_AAAA, 40);
    n_tot++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_c40: got %b want 1", m_busy); end
    wb_rst_ni = 0;
    #1;
    n_tot++; if (m_req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_req_ready: got %b want 1", m_req_ready); end
    n_tot++; if (m_puf_reset !== 1'b1) begin n_bad++; $display("FAIL mid_rst_puf_reset: got %b want 1", m_puf_reset); end
    n_tot++; if (m_chal !== 32'h0) begin n_bad++; $display("FAIL mid_rst_chal: got %h want 0", m_chal); end
    n_tot++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", m_rsp_valid); end
    n_tot++; if (m_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h want 0", m_data); end
    n_tot++; if (m_unst !== 32'h0) begin n_bad++; $display("FAIL mid_rst_unst: got %h want 0", m_unst); end
    n_tot++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", m_busy); end
    @(negedge clk); @(negedge clk);
    n_tot++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hold_busy: got %b want 0", m_busy); end
    n_tot++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hold_valid: got %b want 0", m_rsp_valid); end
    wb_rst_ni = 1;
    run_eval(0, 32'h0F1E_2D3C, 0);
    n_tot++; if (valid_cyc !== 106) begin n_bad++; $display("FAIL mid_valid_cycle: got %0d want 106", valid_cyc); end
    n_tot++; if (m_data !== 32'h3C3C_C3C3) begin n_bad++; $display("FAIL mid_data: got %h want 3c3cc3c3", m_data); end
    n_tot++; if (m_unst !== 32'h0) begin n_bad++; $display("FAIL mid_unst: got %h want 0", m_unst); end
    do_handshake(0);
  endtask

  task automatic test_small;
    pat[0] = 32'hDEAD_BEEF;
    run_eval(1, 32'h0BAD_F00D, 0);
    n_tot++; if (valid_cyc !== 5) begin n_bad++; $display("FAIL small_valid_cycle: got %0d want 5", valid_cyc); end
    n_tot++; if (m_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL small_data: got %h want deadbeef", m_data); end
    n_tot++; if (m_unst !== 32'h0) begin n_bad++; $display("FAIL small_unst: got %h want 0", m_unst); end
    n_tot++; if (pre_len[0] !== 1) begin n_bad++; $display("FAIL small_pre: got %0d want 1", pre_len[0]); end
    n_tot++; if (low_len[0] !== 3) begin n_bad++; $display("FAIL small_settle: got %0d want 3", low_len[0]); end
    do_handshake(1);
    pat[0] = 32'h0000_FFFF;
    run_eval(1, 32'h1111_2222, 0);
    n_tot++; if (valid_cyc !== 5) begin n_bad++; $display("FAIL small2_valid_cycle: got %0d want 5", valid_cyc); end
    n_tot++; if (m_data !== 32'h0000_FFFF) begin n_bad++; $display("FAIL small2_data: got %h want 0000ffff", m_data); end
    n_tot++; if (m_unst !== 32'h0) begin n_bad++; $display("FAIL small2_unst: got %h want 0", m_unst); end
    do_handshake(1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_flaky;
    test_backpressure;
    test_reset_mid;
    test_small;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
